// File: rtl/store_buffer_if.sv
// Core/memory-facing signal bundle of the posted-write store buffer.
// The slave modport is the buffer's view; master is the core/memory side.
interface store_buffer_if;
    logic        st_valid;
    logic [2:0]  st_ctrl;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [2:0]  ld_ctrl;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        empty;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  st_valid, st_ctrl, st_addr, st_data,
        input  ld_valid, ld_ctrl, ld_addr,
        output st_ready, ld_stall, empty,
        output mem_we, mem_ctrl, mem_addr, mem_wdata
    );

    modport master (
        output st_valid, st_ctrl, st_addr, st_data,
        output ld_valid, ld_ctrl, ld_addr,
        input  st_ready, ld_stall, empty,
        input  mem_we, mem_ctrl, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of data_memory. Stores enter a small
// circular FIFO and retire one per cycle when the single memory port is free.
// Loads own the port unless they touch a word still held in the buffer, in
// which case the core is stalled and the head drains until the overlap clears.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0]  ctrl_q [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [PW-1:0]    off;
    logic [DEPTH-1:0] hit;
    logic             hazard;
    logic             drain;
    logic             enq;

    // Address of the last byte touched; wraps inside the 4 KiB window.
    function automatic logic [11:0] last_byte(input logic [2:0] ctrl, input logic [11:0] addr);
        logic [11:0] ext;
        case (ctrl)
            3'b000, 3'b100: ext = 12'd0;
            3'b001, 3'b101: ext = 12'd1;
            default:        ext = 12'd3;
        endcase
        return addr + ext;
    endfunction

    // An access touches at most two words: first and last byte's word index.
    function automatic logic spans_meet(input logic [2:0] ca, input logic [11:0] aa,
                                        input logic [2:0] cb, input logic [11:0] ab);
        logic [11:0] ea;
        logic [11:0] eb;
        ea = last_byte(ca, aa);
        eb = last_byte(cb, ab);
        return (aa[11:2] == ab[11:2]) || (aa[11:2] == eb[11:2]) ||
               (ea[11:2] == ab[11:2]) || (ea[11:2] == eb[11:2]);
    endfunction

    // Per-slot overlap with the presented load; a slot is live if it sits
    // within count entries of head.
    always_comb begin
        hit = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head;
            hit[i] = ({1'b0, off} < count) &&
                     spans_meet(ctrl_q[i], addr_q[i][11:0], bus.ld_ctrl, bus.ld_addr[11:0]);
        end
    end

    assign hazard       = bus.ld_valid && (|hit);
    assign drain        = (count != '0) && (!bus.ld_valid || hazard);
    assign bus.st_ready = (count < CW'(DEPTH)) && !bus.ld_valid;
    assign enq          = bus.st_valid && bus.st_ready;
    assign bus.ld_stall = hazard;
    assign bus.empty    = (count == '0);

    // Port arbitration: a clean load first, then a drain of the head, else idle.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_ctrl  = 3'b010;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.ld_valid && !hazard) begin
            bus.mem_ctrl = bus.ld_ctrl;
            bus.mem_addr = bus.ld_addr;
        end else if (drain) begin
            bus.mem_we    = 1'b1;
            bus.mem_ctrl  = ctrl_q[head];
            bus.mem_addr  = addr_q[head];
            bus.mem_wdata = data_q[head];
        end
    end

    // Pointer and occupancy update; reset drops every pending entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + PW'(1);
            if (drain) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    // Entry payload capture at the tail slot.
    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            ctrl_q[tail] <= bus.st_ctrl;
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: behavioural memory on the mem_* port plus a
// reference built from a program-order store queue over a retired-byte image.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_buffer_if bus ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t        q[$];
    logic [7:0] dev_mem [4096] = '{default: 8'h00};
    logic [7:0] ref_mem [4096] = '{default: 8'h00};
    bit         mem_en = 1'b0;
    int         n_vec  = 0;
    int         n_err  = 0;

    logic        s_we, s_ready, s_stall, s_empty;
    logic [2:0]  s_ctrl;
    logic [31:0] s_addr, s_wdata, s_ld;

    function automatic int wrap(input logic [31:0] a, input int k);
        return (int'(a[11:0]) + k) % 4096;
    endfunction

    function automatic int acc_size(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int store_len(input logic [2:0] c);
        case (c)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit words_meet(input logic [2:0] c1, input logic [31:0] a1,
                                      input logic [2:0] c2, input logic [31:0] a2);
        for (int k = 0; k < acc_size(c1); k++)
            for (int j = 0; j < acc_size(c2); j++)
                if ((wrap(a1, k) / 4) == (wrap(a2, j) / 4)) return 1'b1;
        return 1'b0;
    endfunction

    // Latest program-order value of a byte: newest queued store wins.
    function automatic logic [7:0] po_byte(input int idx);
        logic [7:0] v;
        int         o;
        v = ref_mem[idx];
        foreach (q[i]) begin
            o = (idx - int'(q[i].a[11:0]) + 4096) % 4096;
            if (o < store_len(q[i].c)) v = q[i].d[8*o +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] load_value(input bit from_ref, input logic [2:0] c,
                                               input logic [31:0] a);
        logic [31:0] raw;
        raw = '0;
        for (int k = 0; k < 4; k++)
            raw[8*k +: 8] = from_ref ? po_byte(wrap(a, k)) : dev_mem[wrap(a, k)];
        case (c)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a[11:0] = 12'(4096 - $urandom_range(1, 12));
        else                           a[11:0] = 12'($urandom_range(0, 40));
        return a;
    endfunction

    // Stand-in for data_memory: little-endian byte writes on DMWr.
    always @(posedge clk) begin
        if (mem_en && bus.mem_we === 1'b1)
            for (int k = 0; k < store_len(bus.mem_ctrl); k++)
                dev_mem[wrap(bus.mem_addr, k)] <= bus.mem_wdata[8*k +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit sv, input logic [2:0] sc, input logic [31:0] sa,
                        input logic [31:0] sd, input bit lv, input logic [2:0] lc,
                        input logic [31:0] la, input bit ck);
        bit hz, dr, acc;
        rst_n        = ~rst;
        bus.st_valid = sv;
        bus.st_ctrl  = sc;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_ctrl  = lc;
        bus.ld_addr  = la;
        #2;
        hz = 1'b0;
        if (lv) foreach (q[i]) if (words_meet(q[i].c, q[i].a, lc, la)) hz = 1'b1;
        dr  = (q.size() > 0) && (!lv || hz);
        acc = sv && (q.size() < DEPTH) && !lv;
        s_we = bus.mem_we; s_ctrl = bus.mem_ctrl; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
        s_ready = bus.st_ready; s_stall = bus.ld_stall; s_empty = bus.empty;
        s_ld = load_value(1'b0, bus.mem_ctrl, bus.mem_addr);
        if (ck) begin
            chk("st_ready", 32'(s_ready), 32'((q.size() < DEPTH) && !lv));
            chk("ld_stall", 32'(s_stall), 32'(hz));
            chk("empty", 32'(s_empty), 32'(q.size() == 0));
            if (lv && !hz) begin
                chk("load_we", 32'(s_we), 32'd0);
                chk("load_ctrl", 32'(s_ctrl), 32'(lc));
                chk("load_addr", s_addr, la);
                chk("load_data", s_ld, load_value(1'b1, lc, la));
            end else if (dr) begin
                chk("drain_we", 32'(s_we), 32'd1);
                chk("drain_ctrl", 32'(s_ctrl), 32'(q[0].c));
                chk("drain_addr", s_addr, q[0].a);
                chk("drain_wdata", s_wdata, q[0].d);
            end else begin
                chk("idle_we", 32'(s_we), 32'd0);
                chk("idle_ctrl", 32'(s_ctrl), 32'd2);
                chk("idle_addr", s_addr, 32'd0);
                chk("idle_wdata", s_wdata, 32'd0);
            end
        end
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (dr) begin
                for (int k = 0; k < store_len(q[0].c); k++) ref_mem[wrap(q[0].a, k)] = q[0].d[8*k +: 8];
                void'(q.pop_front());
            end
            if (acc) q.push_back('{c: sc, a: sa, d: sd});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1);
    endtask

    task automatic st(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, c, a, d, 1'b0, 3'd0, 32'd0, 1'b1);
    endtask

    task automatic ld(input logic [2:0] c, input logic [31:0] a);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, c, a, 1'b1);
    endtask

    initial begin
        logic [2:0]  ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  st_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3};
        logic [2:0]  lc, sc;
        logic [31:0] la, sa, sd;
        bit          lv, sv;
        int          r, diffs;

        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0);
        mem_en = 1'b1;

        idle();
        chk("rst_we", 32'(s_we), 32'd0);
        chk("rst_ctrl", 32'(s_ctrl), 32'd2);
        chk("rst_addr", s_addr, 32'd0);
        chk("rst_wdata", s_wdata, 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);

        st(3'd2, 32'h010, 32'hDEADBEEF);
        idle();
        chk("basic_we", 32'(s_we), 32'd1);
        chk("basic_addr", s_addr, 32'h010);
        chk("basic_wdata", s_wdata, 32'hDEADBEEF);
        ld(3'd2, 32'h010);
        chk("basic_ld", s_ld, 32'hDEADBEEF);

        st(3'd0, 32'h103, 32'h7F);
        ld(3'd2, 32'h100);
        chk("hz_stall", 32'(s_stall), 32'd1);
        chk("hz_drain_addr", s_addr, 32'h103);
        ld(3'd2, 32'h100);
        chk("hz_release", 32'(s_stall), 32'd0);
        chk("hz_ld", s_ld, 32'h7F000000);

        st(3'd0, 32'h107, 32'h11);
        st(3'd2, 32'h200, 32'h12345678);
        ld(3'd2, 32'h104);
        chk("seq_stall", 32'(s_stall), 32'd0);
        chk("seq_ld", s_ld, 32'h11000000);

        st(3'd2, 32'h300, 32'hA5A5A5A5);
        ld(3'd2, 32'h400);
        chk("byp_stall", 32'(s_stall), 32'd0);
        chk("byp_we", 32'(s_we), 32'd0);
        chk("byp_addr", s_addr, 32'h400);
        ld(3'd2, 32'h300);
        chk("byp_hz", 32'(s_stall), 32'd1);
        ld(3'd2, 32'h300);
        chk("byp_ld", s_ld, 32'hA5A5A5A5);

        st(3'd2, 32'hFFE, 32'hCAFEF00D);
        ld(3'd0, 32'h000);
        chk("wrap_lo_stall", 32'(s_stall), 32'd1);
        ld(3'd0, 32'h000);
        chk("wrap_lo_ld", s_ld, 32'hFFFFFFFE);
        st(3'd2, 32'hFFE, 32'hCAFEF00D);
        ld(3'd0, 32'hFFE);
        chk("wrap_hi_stall", 32'(s_stall), 32'd1);
        ld(3'd4, 32'hFFE);
        chk("wrap_hi_ld", s_ld, 32'h0000000D);
        st(3'd2, 32'hFFE, 32'h01020304);
        ld(3'd0, 32'h004);
        chk("wrap_byp", 32'(s_stall), 32'd0);

        step(1'b0, 1'b1, 3'd2, 32'h700, 32'h55, 1'b1, 3'd2, 32'h800, 1'b1);
        chk("collide_ready", 32'(s_ready), 32'd0);

        st(3'd3, 32'h500, 32'h99999999);
        idle();
        chk("inv_ctrl", 32'(s_ctrl), 32'd3);
        ld(3'd2, 32'h500);

        for (int i = 0; i < 5; i++) st(3'd2, 32'h020 + 32'(4 * i), 32'h100 + 32'(i));
        idle();

        st(3'd2, 32'h600, 32'h11112222);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'd2, 32'hF00, 1'b1);
        idle();
        chk("rstmid_empty", 32'(s_empty), 32'd1);
        chk("rstmid_we", 32'(s_we), 32'd0);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
        chk("rstmid_mem", 32'(diffs), 32'd0);
        ld(3'd2, 32'h600);

        lc = 3'd2;
        la = 32'd0;
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 9);
            sv = (r <= 4) || (r == 8);
            lv = (r >= 5) && (r <= 8);
            if (s_stall === 1'b1) lv = 1'b1;
            else begin
                lc = ld_codes[$urandom_range(0, 4)];
                la = rand_addr();
            end
            sc = st_codes[$urandom_range(0, 4)];
            sa = rand_addr();
            sd = $urandom;
            step(1'b0, sv, sc, sa, sd, lv, lc, la, 1'b1);
        end

        for (int i = 0; i < 3; i++) idle();
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (dev_mem[i] !== ref_mem[i]) diffs++;
        chk("final_mem", 32'(diffs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
